// File: rtl/sid_pkg.sv
// Shared types and constants for the SID bus writer: pair layout, FSM encodings
// and the address-byte qualifier.
package sid_pkg;

  localparam int SID_ADDR_W       = 5;
  localparam int SID_DATA_W       = 8;
  localparam int SID_PAIR_W       = SID_ADDR_W + SID_DATA_W;
  localparam int PHI2_DIV_DEFAULT = 12;

  typedef struct packed {
    logic [SID_ADDR_W-1:0] addr;
    logic [SID_DATA_W-1:0] data;
  } sid_pair_t;

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    BUS_WRITE = 2'd1,
    BUS_GAP   = 2'd2
  } bus_state_t;

  typedef enum logic {
    PAIR_WAIT_ADDR = 1'b0,
    PAIR_WAIT_DATA = 1'b1
  } pair_state_t;

  // Only bytes 0x00..0x1F name a SID register; anything else is noise.
  function automatic logic is_addr_byte(input logic [7:0] b);
    return (b[7:5] == 3'b000);
  endfunction

endpackage

// File: rtl/sid_bus_writer_fifo.sv
// Small synchronous FIFO with occupancy count; a push into a full FIFO is
// accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status flags and accept qualification
  always_comb begin
    full      = (count_r == (AW+1)'(DEPTH));
    empty     = (count_r == {(AW+1){1'b0}});
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
  end

  assign rdata = mem_r[rd_ptr_r];
  assign count = count_r;

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      count_r <= count_r + (AW+1)'(push_ok_s) - (AW+1)'(pop_ok_s);
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/sid_bus_writer.sv
// Pairs UART bytes into SID register writes, queues them, and replays them on
// the SID bus with phi2-aligned write cycles.
module sid_bus_writer import sid_pkg::*; #(
  parameter int CLK_FREQ       = 12_000_000,
  parameter int PHI2_DIV       = PHI2_DIV_DEFAULT,
  parameter int TIMEOUT_CYCLES = 2083,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                  CLK_IN,
  input  logic                  RST_IN,
  input  logic [SID_DATA_W-1:0] rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  phi2_o,
  output logic                  sid_cs_n_o,
  output logic                  sid_rw_o,
  output logic [SID_ADDR_W-1:0] sid_addr_o,
  output logic [SID_DATA_W-1:0] sid_data_o,
  output logic                  sid_data_oe_o,
  output logic                  overflow_o,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(PHI2_DIV);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHI2_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(PHI2_DIV / 2);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  if (CLK_FREQ <= 0 || PHI2_DIV < 4 || (PHI2_DIV % 2) != 0 || TIMEOUT_CYCLES < 1 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("sid_bus_writer: invalid parameter set");
  end

  logic [CNT_W-1:0] phi_cnt_r, phi_cnt_nxt_s;
  logic             phi2_r, wrap_s;
  pair_state_t      pair_state_r, pair_state_nxt_s;
  logic [SID_ADDR_W-1:0] addr_hold_r, addr_hold_nxt_s;
  logic [TMO_W-1:0] tmo_r, tmo_nxt_s;
  logic             push_s, push_acc_s, pop_s, end_write_s, nonempty_nxt_s;
  sid_pair_t        push_pair_s, head_s;
  logic             fifo_full_s, fifo_empty_s;
  logic [FCW-1:0]   fifo_count_s;
  bus_state_t       bus_state_r, bus_state_nxt_s;
  logic             cs_n_r, rw_r, oe_r, ovf_r, busy_r;
  logic [SID_ADDR_W-1:0] addr_r;
  logic [SID_DATA_W-1:0] data_r;

  // Phi2 counter next value; the cycle before the wrap is the bus decision point
  always_comb begin
    wrap_s = (phi_cnt_r == CNT_LAST);
    if (wrap_s) begin
      phi_cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      phi_cnt_nxt_s = phi_cnt_r + CNT_W'(1'b1);
    end
  end

  // Phi2 counter and registered phi2 level
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      phi_cnt_r <= {CNT_W{1'b0}};
      phi2_r    <= 1'b0;
    end else begin
      phi_cnt_r <= phi_cnt_nxt_s;
      phi2_r    <= (phi_cnt_nxt_s >= CNT_HALF);
    end
  end

  // Pairing FSM next state: address byte, then data byte within the timeout
  always_comb begin
    pair_state_nxt_s = pair_state_r;
    addr_hold_nxt_s  = addr_hold_r;
    tmo_nxt_s        = tmo_r;
    push_s           = 1'b0;
    push_pair_s      = '{addr: addr_hold_r, data: rx_data_i};
    case (pair_state_r)
      PAIR_WAIT_ADDR: begin
        if (rx_valid_i && is_addr_byte(rx_data_i)) begin
          addr_hold_nxt_s  = rx_data_i[SID_ADDR_W-1:0];
          tmo_nxt_s        = {TMO_W{1'b0}};
          pair_state_nxt_s = PAIR_WAIT_DATA;
        end else begin
          pair_state_nxt_s = PAIR_WAIT_ADDR;
        end
      end
      PAIR_WAIT_DATA: begin
        if (rx_valid_i) begin
          push_s           = 1'b1;
          pair_state_nxt_s = PAIR_WAIT_ADDR;
        end else if (tmo_r == TMO_LAST) begin
          pair_state_nxt_s = PAIR_WAIT_ADDR;
        end else begin
          tmo_nxt_s = tmo_r + TMO_W'(1'b1);
        end
      end
      default: pair_state_nxt_s = PAIR_WAIT_ADDR;
    endcase
  end

  // Pairing FSM registers
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      pair_state_r <= PAIR_WAIT_ADDR;
      addr_hold_r  <= {SID_ADDR_W{1'b0}};
      tmo_r        <= {TMO_W{1'b0}};
    end else begin
      pair_state_r <= pair_state_nxt_s;
      addr_hold_r  <= addr_hold_nxt_s;
      tmo_r        <= tmo_nxt_s;
    end
  end

  sync_fifo #(
    .WIDTH(SID_PAIR_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK_IN),
    .rst  (RST_IN),
    .push (push_s),
    .wdata(push_pair_s),
    .pop  (pop_s),
    .rdata(head_s),
    .full (fifo_full_s),
    .empty(fifo_empty_s),
    .count(fifo_count_s)
  );

  // Bus FSM next state; writes start only on the edge where phi2 falls
  always_comb begin
    bus_state_nxt_s = bus_state_r;
    pop_s           = 1'b0;
    end_write_s     = 1'b0;
    case (bus_state_r)
      BUS_IDLE: begin
        if (wrap_s && !fifo_empty_s) begin
          pop_s           = 1'b1;
          bus_state_nxt_s = BUS_WRITE;
        end else begin
          bus_state_nxt_s = BUS_IDLE;
        end
      end
      BUS_WRITE: begin
        if (wrap_s) begin
          end_write_s     = 1'b1;
          bus_state_nxt_s = BUS_GAP;
        end else begin
          bus_state_nxt_s = BUS_WRITE;
        end
      end
      BUS_GAP: begin
        if (wrap_s && !fifo_empty_s) begin
          pop_s           = 1'b1;
          bus_state_nxt_s = BUS_WRITE;
        end else if (wrap_s) begin
          bus_state_nxt_s = BUS_IDLE;
        end else begin
          bus_state_nxt_s = BUS_GAP;
        end
      end
      default: bus_state_nxt_s = BUS_IDLE;
    endcase
    push_acc_s     = push_s && (!fifo_full_s || pop_s);
    nonempty_nxt_s = push_acc_s || (fifo_count_s > FCW'(pop_s));
  end

  // Bus FSM state and registered SID pins, overflow and busy
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      bus_state_r <= BUS_IDLE;
      cs_n_r      <= 1'b1;
      rw_r        <= 1'b1;
      oe_r        <= 1'b0;
      addr_r      <= {SID_ADDR_W{1'b0}};
      data_r      <= {SID_DATA_W{1'b0}};
      ovf_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      bus_state_r <= bus_state_nxt_s;
      if (pop_s) begin
        addr_r <= head_s.addr;
        data_r <= head_s.data;
        cs_n_r <= 1'b0;
        rw_r   <= 1'b0;
        oe_r   <= 1'b1;
      end else if (end_write_s) begin
        cs_n_r <= 1'b1;
        rw_r   <= 1'b1;
        oe_r   <= 1'b0;
      end
      if (push_s && !push_acc_s) ovf_r <= 1'b1;
      busy_r <= nonempty_nxt_s || (bus_state_nxt_s != BUS_IDLE);
    end
  end

  assign phi2_o        = phi2_r;
  assign sid_cs_n_o    = cs_n_r;
  assign sid_rw_o      = rw_r;
  assign sid_data_oe_o = oe_r;
  assign sid_addr_o    = addr_r;
  assign sid_data_o    = data_r;
  assign overflow_o    = ovf_r;
  assign busy_o        = busy_r;

endmodule

// File: tb/tb_sid_bus_writer.sv
// Self-checking bench for sid_bus_writer: a slot-based model of pairing, queueing
// and phi2-aligned writes is compared every cycle, plus literal write-log checks.
module tb_sid_bus_writer;

  localparam int DIV   = 12;
  localparam int TMO   = 2083;
  localparam int DEPTH = 4;
  localparam int RESET_VEC = 'h30000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       phi2, cs_n, rw, oe, ovf, busy;
  logic [4:0] addr;
  logic [7:0] data;

  always #5 clk = ~clk;

  sid_bus_writer #(
    .CLK_FREQ(12_000_000), .PHI2_DIV(DIV), .TIMEOUT_CYCLES(TMO), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK_IN(clk), .RST_IN(rst), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .phi2_o(phi2), .sid_cs_n_o(cs_n), .sid_rw_o(rw), .sid_addr_o(addr),
    .sid_data_o(data), .sid_data_oe_o(oe), .overflow_o(ovf), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  // model state: n is the index of the current cycle since reset
  bit          mvalid = 1'b0;
  int          n = 0;
  bit          pend = 1'b0;
  logic [4:0]  pend_addr = 5'd0;
  int          pend_cyc = 0;
  logic [12:0] q[$];
  int          wr_start = 0, wr_end = 0, next_ok = 0;
  logic [4:0]  m_addr = 5'd0;
  logic [7:0]  m_data = 8'd0;
  bit          m_ovf = 1'b0;

  int log_addr[$], log_data[$], log_start[$], log_len[$];

  // Model advance: pairing by timestamps, writes only in phi2 slots two periods apart
  always @(posedge clk) begin : model
    int c;
    bit do_push;
    logic [12:0] pair_v, head_v;
    if (rst) begin
      mvalid = 1'b1; n = 0; pend = 1'b0; q.delete();
      wr_start = 0; wr_end = 0; next_ok = 0;
      m_addr = 5'd0; m_data = 8'd0; m_ovf = 1'b0;
    end else if (mvalid) begin
      c = n; do_push = 1'b0; pair_v = 13'd0;
      if (rx_valid) begin
        if (pend && (c - pend_cyc) <= TMO) begin
          do_push = 1'b1; pair_v = {pend_addr, rx_data}; pend = 1'b0;
        end else begin
          pend = (rx_data[7:5] == 3'b000); pend_addr = rx_data[4:0]; pend_cyc = c;
        end
      end
      if (((c + 1) % DIV) == 0 && (c + 1) >= next_ok && q.size() > 0) begin
        head_v = q.pop_front();
        m_addr = head_v[12:8]; m_data = head_v[7:0];
        wr_start = c + 1; wr_end = c + 1 + DIV; next_ok = c + 1 + 2 * DIV;
      end
      if (do_push) begin
        if (q.size() < DEPTH) q.push_back(pair_v);
        else m_ovf = 1'b1;
      end
      n = c + 1;
    end
  end

  function automatic logic [18:0] dut_vec();
    return {phi2, cs_n, rw, oe, addr, data, ovf, busy};
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic compare_loop();
    bit prev_cs = 1'b1;
    bit exp_cs;
    logic [18:0] exp_v;
    forever begin
      @(negedge clk);
      if (mvalid) begin
        exp_cs = !(n >= wr_start && n < wr_end);
        exp_v = {((n % DIV) >= DIV / 2), exp_cs, exp_cs, !exp_cs, m_addr, m_data, m_ovf,
                 (q.size() > 0 || n < next_ok)};
        checks++;
        if (dut_vec() !== exp_v) begin
          errors++;
          $display("FAIL cycle_compare n=%0d got %05h expected %05h", n, dut_vec(), exp_v);
        end
        if (prev_cs && cs_n === 1'b0) begin
          log_start.push_back(n); log_addr.push_back(int'(addr)); log_data.push_back(int'(data));
        end
        if (!prev_cs && cs_n === 1'b1 && log_start.size() > 0)
          log_len.push_back(n - log_start[log_start.size() - 1]);
        prev_cs = (cs_n === 1'b0) ? 1'b0 : 1'b1;
      end
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (busy === 1'b0) break;
    end
    check(name, (busy === 1'b0) ? 0 : 1, 0);
  endtask

  task automatic main_seq();
    rst = 1'b1;
    idle(3);
    check("reset_state", int'(dut_vec()), RESET_VEC);
    rst = 1'b0;
    idle(5);

    send(8'h18); send(8'h0F);
    wait_idle("t1_idle");
    check("t1_count", log_addr.size(), 1);
    check("t1_addr", log_addr[0], 'h18);
    check("t1_data", log_data[0], 'h0F);
    check("t1_len", log_len[0], 12);
    check("t1_align", log_start[0] % DIV, 0);

    send(8'h00); idle(TMO + 10); send(8'h05); send(8'h55);
    wait_idle("t2_idle");
    check("t2_count", log_addr.size(), 2);
    check("t2_addr", log_addr[1], 'h05);
    check("t2_data", log_data[1], 'h55);

    send(8'h02); idle(TMO - 1); send(8'h66);
    wait_idle("tmo_edge_idle");
    check("tmo_edge_count", log_addr.size(), 3);
    check("tmo_edge_addr", log_addr[2], 'h02);
    check("tmo_edge_data", log_data[2], 'h66);
    send(8'h03); idle(TMO); send(8'h77);
    wait_idle("tmo_late_idle");
    check("tmo_late_count", log_addr.size(), 3);

    send(8'h20); send(8'h01); send(8'h07);
    wait_idle("t3_idle");
    check("t3_count", log_addr.size(), 4);
    check("t3_addr", log_addr[3], 'h01);
    check("t3_data", log_data[3], 'h07);
    check("t3_ovf", int'(ovf), 0);

    send(8'h01); send(8'h07); send(8'h04); send(8'h11);
    wait_idle("t5_idle");
    check("t5_count", log_addr.size(), 6);
    check("t5_first", log_addr[4] * 256 + log_data[4], 'h107);
    check("t5_second", log_addr[5] * 256 + log_data[5], 'h411);
    check("t5_gap", log_start[5] - log_start[4] - log_len[4], 12);
    check("t5_hold", int'(addr) * 256 + int'(data), 'h411);

    for (int i = 0; i < DIV; i++) begin
      if ((n % DIV) == 6) break;
      @(negedge clk);
    end
    for (int i = 0; i < 6; i++) begin
      send(8'(i)); send(8'(8'hA0 + i));
    end
    wait_idle("t4_idle");
    check("t4_count", log_addr.size(), 11);
    for (int j = 0; j < 5; j++) begin
      check($sformatf("t4_addr%0d", j), log_addr[6 + j], j);
      check($sformatf("t4_data%0d", j), log_data[6 + j], 'hA0 + j);
    end
    for (int j = 0; j < 4; j++)
      check($sformatf("t4_spacing%0d", j), log_start[7 + j] - log_start[6 + j], 24);
    check("t4_ovf", int'(ovf), 1);

    send(8'h0A); send(8'h01); send(8'h0B); send(8'h02); send(8'h0C); send(8'h03);
    for (int i = 0; i < 100; i++) begin
      if (cs_n === 1'b0) break;
      @(negedge clk);
    end
    check("t6_started", (cs_n === 1'b0) ? 0 : 1, 0);
    idle(3);
    check("t6_log", log_addr.size(), 12);
    rst = 1'b1;
    @(negedge clk);
    check("t6_reset_vec", int'(dut_vec()), RESET_VEC);
    rst = 1'b0;
    idle(100);
    check("t6_no_more", log_addr.size(), 12);
    check("t6_busy", (busy === 1'b0) ? 0 : 1, 0);
  endtask

  initial begin
    fork
      compare_loop();
      main_seq();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
